// File: rtl/escape_color_pipeline_pkg.sv
// Shared types and constants for the escape-count colouring pipeline.
// Holds the sample mode encoding and the 16-entry power-up palette.
package escape_color_pipeline_pkg;

    typedef enum logic [1:0] {
        DIRECT = 2'd0,
        INTERP = 2'd1,
        GREY   = 2'd2,
        RSVD   = 2'd3
    } mode_e;

    localparam int DEF_PAL_N = 16;

    // {R,G,B}, 8 bits per channel
    localparam logic [23:0] DEFAULT_PALETTE [DEF_PAL_N] = '{
        24'h1415FF, 24'h1EA18F, 24'h22B14C, 24'hFFF200,
        24'hFF7F27, 24'hED1C24, 24'hA349A4, 24'h3F48CC,
        24'h00A2E8, 24'hB5E61D, 24'hFFC90E, 24'hC8BFE7,
        24'h7092BE, 24'h99D9EA, 24'hEFE4B0, 24'hFFFFFF
    };

endpackage

// File: rtl/escape_color_pipeline_lerp.sv
// One colour channel of the interpolate blend: c0 + floor((c1 - c0) * frac / 2^FRAC_W).
module channel_lerp #(
    parameter int CH_W   = 8,
    parameter int FRAC_W = 4
) (
    input  logic [CH_W-1:0]   c0,
    input  logic [CH_W-1:0]   c1,
    input  logic [FRAC_W-1:0] frac,
    output logic [CH_W-1:0]   c
);

    localparam int PW = CH_W + FRAC_W + 2;
    localparam logic signed [PW-1:0] CH_MAX = PW'((2 ** CH_W) - 1);

    logic signed [CH_W:0]   diff;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   step;
    logic signed [PW-1:0]   sum;

    // frac < 2^FRAC_W keeps the result between c0 and c1; the clamp only guards the cast
    function automatic logic [CH_W-1:0] sat_ch(input logic signed [PW-1:0] v);
        if (v < 0)
            return '0;
        else if (v > CH_MAX)
            return '1;
        else
            return v[CH_W-1:0];
    endfunction

    always_comb begin
        diff = $signed({1'b0, c1}) - $signed({1'b0, c0});
        prod = PW'(diff) * PW'($signed({1'b0, frac}));
        step = prod >>> FRAC_W;
        sum  = PW'($signed({1'b0, c0})) + step;
        c    = sat_ch(sum);
    end

endmodule

// File: rtl/escape_color_pipeline.sv
// Maps escape counts to RGB through a rotatable palette: capture/index, palette read, blend/output.
module escape_color_pipeline
    import escape_color_pipeline_pkg::*;
#(
    parameter int ESC_W     = 8,
    parameter int PAL_DEPTH = 16,
    parameter int CH_W      = 8,
    parameter int FRAC_W    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ESC_W-1:0]              escape,
    input  logic [1:0]                    mode,
    input  logic [ESC_W-1:0]              max_iter,
    input  logic                          pal_we,
    input  logic [$clog2(PAL_DEPTH)-1:0]  pal_addr,
    input  logic [3*CH_W-1:0]             pal_wdata,
    input  logic                          rotate_tick,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CH_W-1:0]               R,
    output logic [CH_W-1:0]               G,
    output logic [CH_W-1:0]               B
);

    localparam int IDX_W = $clog2(PAL_DEPTH);
    localparam int PAL_W = 3 * CH_W;

    logic [PAL_W-1:0]  palette [PAL_DEPTH];
    logic [IDX_W-1:0]  offset;
    logic              advance;

    logic              vld_p0, vld_p1, vld_p2;
    logic [IDX_W-1:0]  idx_p0;
    logic [FRAC_W-1:0] frac_p0, frac_p1;
    mode_e             mode_p0, mode_p1;
    logic              inside_p0, inside_p1;
    logic [CH_W-1:0]   grey_p0, grey_p1;
    logic [PAL_W-1:0]  c0_p1, c1_p1;

    mode_e             mode_in;
    logic [ESC_W-1:0]  esc_sh;
    logic [IDX_W-1:0]  idx_in;
    logic [IDX_W-1:0]  idx_nxt;
    logic [CH_W-1:0]   lerp_r, lerp_g, lerp_b;
    logic [CH_W-1:0]   r_nxt, g_nxt, b_nxt;

    // Each 8-bit default channel is rescaled MSB-first into CH_W bits
    function automatic logic [PAL_W-1:0] default_entry(input int i);
        logic [23:0]      raw;
        logic [PAL_W-1:0] res;
        raw = DEFAULT_PALETTE[i[3:0]];
        for (int ch = 0; ch < 3; ch++)
            res[ch*CH_W +: CH_W] = CH_W'({raw[ch*8 +: 8], {CH_W{1'b0}}} >> 8);
        return res;
    endfunction

    assign advance   = ~vld_p2 | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_p2;
    assign idx_nxt   = idx_p0 + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PAL_DEPTH; i++)
                palette[i] <= default_entry(i);
        end else if (pal_we) begin
            palette[pal_addr] <= pal_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            offset <= '0;
        else if (rotate_tick)
            offset <= offset + 1'b1;
    end

    always_comb begin
        mode_in = (mode == RSVD) ? DIRECT : mode_e'(mode);
        esc_sh  = (mode_in == INTERP) ? (escape >> FRAC_W) : escape;
        idx_in  = esc_sh[IDX_W-1:0] + offset;
    end

    // Stage p0: capture and palette index; stage p1: palette read
    always_ff @(posedge clk) begin
        if (advance) begin
            idx_p0    <= idx_in;
            frac_p0   <= escape[FRAC_W-1:0];
            mode_p0   <= mode_in;
            inside_p0 <= (escape == max_iter);
            grey_p0   <= escape[ESC_W-1 -: CH_W];
            c0_p1     <= palette[idx_p0];
            c1_p1     <= palette[idx_nxt];
            frac_p1   <= frac_p0;
            mode_p1   <= mode_p0;
            inside_p1 <= inside_p0;
            grey_p1   <= grey_p0;
        end
    end

    channel_lerp #(.CH_W(CH_W), .FRAC_W(FRAC_W)) u_lerp_r (
        .c0(c0_p1[2*CH_W +: CH_W]), .c1(c1_p1[2*CH_W +: CH_W]), .frac(frac_p1), .c(lerp_r));
    channel_lerp #(.CH_W(CH_W), .FRAC_W(FRAC_W)) u_lerp_g (
        .c0(c0_p1[CH_W +: CH_W]),   .c1(c1_p1[CH_W +: CH_W]),   .frac(frac_p1), .c(lerp_g));
    channel_lerp #(.CH_W(CH_W), .FRAC_W(FRAC_W)) u_lerp_b (
        .c0(c0_p1[0 +: CH_W]),      .c1(c1_p1[0 +: CH_W]),      .frac(frac_p1), .c(lerp_b));

    always_comb begin
        r_nxt = c0_p1[2*CH_W +: CH_W];
        g_nxt = c0_p1[CH_W +: CH_W];
        b_nxt = c0_p1[0 +: CH_W];
        if (inside_p1) begin
            r_nxt = '0;
            g_nxt = '0;
            b_nxt = '0;
        end else if (mode_p1 == GREY) begin
            r_nxt = grey_p1;
            g_nxt = grey_p1;
            b_nxt = grey_p1;
        end else if (mode_p1 == INTERP) begin
            r_nxt = lerp_r;
            g_nxt = lerp_g;
            b_nxt = lerp_b;
        end
    end

    // Stage p2: registered colour output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            R      <= '0;
            G      <= '0;
            B      <= '0;
        end else if (advance) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                R <= r_nxt;
                G <= g_nxt;
                B <= b_nxt;
            end
        end
    end

endmodule

// File: tb/tb_escape_color_pipeline.sv
// Scoreboard bench for escape_color_pipeline with hand-computed colour vectors.
module tb_escape_color_pipeline;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  escape;
    logic [1:0]  mode;
    logic [7:0]  max_iter;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [23:0] pal_wdata;
    logic        rotate_tick;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  R, G, B;

    int          tests = 0;
    int          fails = 0;
    logic [23:0] exp_q [$];

    escape_color_pipeline #(.ESC_W(8), .PAL_DEPTH(16), .CH_W(8), .FRAC_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .escape(escape), .mode(mode), .max_iter(max_iter),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .rotate_tick(rotate_tick), .out_valid(out_valid), .out_ready(out_ready),
        .R(R), .G(G), .B(B));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] esc, input logic [1:0] md,
                        input logic [7:0] mx, input logic [23:0] exp);
        int n;
        escape   = esc;
        mode     = md;
        max_iter = mx;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: got in_ready 0 expected 1 (escape %h)", esc);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rotate_tick = 1'b1;
        @(posedge clk);
        #1;
        rotate_tick = 1'b0;
    endtask

    // Monitor: pops expected colours, checks stall behaviour
    initial begin
        logic        prev_hold;
        logic [23:0] prev_rgb;
        logic [23:0] exp;
        prev_hold = 1'b0;
        prev_rgb  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (out_valid && !out_ready) begin
                    tests++;
                    if (in_ready !== 1'b0) begin
                        fails++;
                        $display("FAIL stall_in_ready: got %b expected 0", in_ready);
                    end
                    if (prev_hold) begin
                        tests++;
                        if ({R, G, B} !== prev_rgb) begin
                            fails++;
                            $display("FAIL stall_hold: got %h expected %h", {R, G, B}, prev_rgb);
                        end
                    end
                    prev_hold = 1'b1;
                    prev_rgb  = {R, G, B};
                end else begin
                    prev_hold = 1'b0;
                end
                if (out_valid && out_ready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL sb_unexpected: got %h expected no output", {R, G, B});
                    end else begin
                        exp = exp_q.pop_front();
                        if ({R, G, B} !== exp) begin
                            fails++;
                            $display("FAIL sb_rgb: got %h expected %h", {R, G, B}, exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0]  s_esc [8];
        logic [1:0]  s_md  [8];
        logic [23:0] s_exp [8];
        int          lat;

        reset = 1'b1; in_valid = 1'b0; escape = '0; mode = '0; max_iter = 8'hFF;
        pal_we = 1'b0; pal_addr = '0; pal_wdata = '0; rotate_tick = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_rgb", {R, G, B}, 0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Direct entry 0 with latency measurement
        send(8'h00, 2'd0, 8'hFF, 24'h1415FF);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 3);
        drain();

        send(8'h08, 2'd1, 8'hFF, 24'h195BC7);  // interp entry0->entry1 at 8/16
        send(8'h40, 2'd0, 8'h40, 24'h000000);  // inside set
        send(8'h80, 2'd2, 8'hFF, 24'h808080);  // grey ramp
        send(8'h02, 2'd3, 8'hFF, 24'h22B14C);  // reserved acts as direct
        send(8'h1F, 2'd1, 8'hFF, 24'h21B050);  // interp entry1->entry2, negative floor on B
        send(8'hF4, 2'd1, 8'hFF, 24'hC4C4FF);  // interp wraps entry15->entry0
        send(8'h33, 2'd1, 8'h33, 24'h000000);  // inside set in interp mode
        drain();

        // Palette write lands on the edge where the first sample reads entry 0
        send(8'h00, 2'd0, 8'hFF, 24'h1415FF);
        pal_we = 1'b1; pal_addr = 4'd0; pal_wdata = 24'h000000;
        send(8'h00, 2'd0, 8'hFF, 24'h000000);
        pal_we = 1'b0;
        drain();

        // Reset with two samples in flight
        send(8'h01, 2'd0, 8'hFF, 24'h1EA18F);
        send(8'h00, 2'd0, 8'hFF, 24'h000000);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(8'h00, 2'd0, 8'hFF, 24'h1415FF);  // palette[0] restored
        drain();

        // Stream of 8 with a 4-cycle downstream stall
        for (int i = 0; i < 8; i++) begin
            s_esc[i] = 8'(i * 8'h11);
            s_md[i]  = 2'd2;
            s_exp[i] = {s_esc[i], s_esc[i], s_esc[i]};
        end
        s_esc[3] = 8'h03; s_md[3] = 2'd0; s_exp[3] = 24'hFFF200;
        s_esc[6] = 8'h0A; s_md[6] = 2'd0; s_exp[6] = 24'hFFC90E;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(s_esc[i], s_md[i], 8'hFF, s_exp[i]);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Rotation: two ticks, then wrap back to offset 0
        tick();
        tick();
        send(8'h0F, 2'd0, 8'hFF, 24'h1EA18F);
        send(8'hA5, 2'd2, 8'hFF, 24'hA5A5A5);
        for (int i = 0; i < 14; i++)
            tick();
        send(8'h00, 2'd0, 8'hFF, 24'h1415FF);
        drain();

        repeat (3) @(posedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/escape_color_pipeline.md
ESCAPE_COLOR_PIPELINE -- requirements
Module: escape_color_pipeline

Interface
REQ-001 SHALL have parameter ESC_W, default 8, escape-count width.
REQ-002 SHALL have parameter PAL_DEPTH, default 16, palette entries; power of two, 2..256.
REQ-003 SHALL have parameter CH_W, default 8, per-channel colour width; CH_W <= ESC_W.
REQ-004 SHALL have parameter FRAC_W, default 4, fractional escape bits used by interpolate mode; FRAC_W < ESC_W.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  escape sample offered.
REQ-008 SHALL have port in_ready  output  1  sample accepted when in_valid & in_ready.
REQ-009 SHALL have port escape  input  ESC_W  escape count of the pixel.
REQ-010 SHALL have port mode  input  2  0 direct, 1 interpolate, 2 grey ramp, 3 reserved (treated as 0); captured with the sample.
REQ-011 SHALL have port max_iter  input  ESC_W  escape value denoting inside-set; captured with the sample.
REQ-012 SHALL have port pal_we, pal_addr, pal_wdata  input  1 / log2(PAL_DEPTH) / 3*CH_W  palette write port, {R,G,B} packing.
REQ-013 SHALL have port rotate_tick  input  1  single-cycle pulse advancing palette rotation offset.
REQ-014 SHALL have port out_valid  output  1  colour available.
REQ-015 SHALL have port out_ready  input  1  downstream accepts colour.
REQ-016 SHALL have ports R, G, B  output  CH_W each  registered colour channels.

Function
REQ-017 SHALL be a 3-stage pipeline: S1 capture/index, S2 palette read, S3 blend/output; latency exactly 3 cycles from accept to out_valid with out_ready held high.
REQ-018 SHALL advance all stages only when ~out_valid | out_ready; in_ready SHALL equal that condition (combinational); stalled stages hold contents unchanged.
REQ-019 SHALL sustain one sample per cycle with continuous out_ready.
REQ-020 SHALL compute idx = ((escape >> sh) + offset) mod PAL_DEPTH, sh = FRAC_W in mode 1, else 0; frac = escape[FRAC_W-1:0].
REQ-021 Mode 0 SHALL output palette[idx].
REQ-022 Mode 1 SHALL output per channel c0 + (((c1 - c0) * frac) >>> FRAC_W), c0 = palette[idx], c1 = palette[(idx+1) mod PAL_DEPTH], signed difference, arithmetic (floor) shift, result in range of CH_W.
REQ-023 Mode 2 SHALL output R = G = B = escape[ESC_W-1 -: CH_W], ignoring palette and offset.
REQ-024 When escape == max_iter, SHALL output 0 on all channels regardless of mode.
REQ-025 offset (log2(PAL_DEPTH) bits) SHALL increment by 1 on rotate_tick, wrapping to 0 at PAL_DEPTH; S1 uses offset value before a same-cycle increment.
REQ-026 Palette write SHALL take effect at the clock edge; an S2 read in the same cycle as a write to that address SHALL return the old value.
REQ-027 Palette writes and rotate_tick SHALL be honoured during stalls.

Reset
REQ-028 On reset: out_valid = 0, R = G = B = 0, all stage valids 0, offset = 0, in-flight samples discarded.
REQ-029 On reset palette[i] SHALL load DEFAULT_PALETTE[i mod 16] truncated/taken MSB-first to CH_W per channel; reset mid-stream SHALL restore defaults, discarding prior writes.
REQ-030 in_ready SHALL read 1 while reset is deasserted and pipeline empty.

Structure
REQ-031 Shared package SHALL hold the mode enum (DIRECT, INTERP, GREY, RSVD) and DEFAULT_PALETTE[16] of 24-bit entries, entry 0 = 24'h1415FF, entry 1 = 24'h1EA18F.
REQ-032 Per-channel blend SHALL be one sub-module, channel_lerp (c0, c1, frac -> c), instantiated three times.

Verification
REQ-033 Reset, mode 0, escape 8'h00, max_iter 8'hFF, out_ready 1 -> 3 cycles later out_valid, {R,G,B} = 24'h1415FF.
REQ-034 Mode 1, escape 8'h08 -> {R,G,B} = 24'h195BC7 (entry 0 to entry 1 at frac 8/16).
REQ-035 escape 8'h40 = max_iter 8'h40, mode 0 -> 24'h000000; mode 2, escape 8'h80, max_iter 8'hFF -> 24'h808080.
REQ-036 Two rotate_tick pulses then mode 0 escape 8'h0F -> palette[1] colour 24'h1EA18F (index wraps 17 mod 16).
REQ-037 Stream 8 samples, out_ready low for 4 cycles mid-stream -> in_ready low while stalled, no sample lost/duplicated, order preserved, outputs stable while out_valid & ~out_ready.
REQ-038 Write palette[0] = 24'h000000 same cycle as S2 reads index 0 -> that sample returns 24'h1415FF, next returns 24'h000000; assert reset mid-stream -> out_valid 0 next edge, palette[0] back to 24'h1415FF.
